// File: rtl/eib.sv
// rtl/eib.sv - exception/interrupt block: vector table, trap save, pending/enable, halt control
`ifndef VECTOR_ADDR
`define VECTOR_ADDR (BASE + 32'h0000_0000)
`endif
`ifndef TRAP_ADDR
`define TRAP_ADDR (BASE + 32'h0000_0020)
`endif

module eib #(
  parameter logic [31:0] BASE = 32'h0000_0100,
  parameter int          NIRQ = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            strobe,
  input  logic            rw,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NIRQ-1:0] irq,
  output logic            trap,
  output logic            halt
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [31:0] VEC_ADDR  = `VECTOR_ADDR;
  localparam logic [31:0] TRAP_ADDR = `TRAP_ADDR;

  logic [31:0]     vec_q [32];
  logic [31:0]     tsave_q;
  logic [NIRQ-1:0] pend_q;
  logic [NIRQ-1:0] enable_q;
  logic            haltctl_q;
  logic [4:0]      cause_q;
  logic            trap_q;
  state_t          state_q, state_d;

  logic [NIRQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [1:0]      warm_q;

  logic            sel;
  logic [5:0]      off;
  logic            wr;
  logic            wr_vec, wr_tsave, wr_pend, wr_enable, wr_haltctl, wr_eoi;
  logic [NIRQ-1:0] pe;
  logic [NIRQ-1:0] irq_rise;
  logic [NIRQ-1:0] pend_clr;
  logic [4:0]      lowest;

  assign sel = (addr[31:6] == BASE[31:6]);
  assign off = addr[5:0];
  assign wr  = strobe && rw && sel;

  assign wr_vec     = wr && (addr[31:5] == VEC_ADDR[31:5]);
  assign wr_tsave   = wr && (addr == TRAP_ADDR);
  assign wr_pend    = wr && (off == 6'h21);
  assign wr_enable  = wr && (off == 6'h22);
  assign wr_haltctl = wr && (off == 6'h23);
  assign wr_eoi     = wr && (off == 6'h25);

  assign pe       = pend_q & enable_q;
  assign pend_clr = wr_pend ? wdata[NIRQ-1:0] : '0;
  // Edges are only trusted once the sync chain has refilled after reset, so
  // levels that were already high during reset do not look like new edges.
  assign irq_rise = (warm_q == 2'd3) ? (sync2_q & ~sync3_q) : '0;

  assign trap = trap_q;
  assign halt = haltctl_q;

  // Lowest set index of the enabled pending vector.
  always_comb begin
    lowest = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pe[i]) lowest = i[4:0];
    end
  end

  // Two-flop synchronizer plus edge-history flop and post-reset warm-up counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Vector table writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) vec_q[i] <= '0;
    end else if (wr_vec) begin
      vec_q[off[4:0]] <= wdata;
    end
  end

  // Control registers; on PEND a new edge beats a coincident W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tsave_q   <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      haltctl_q <= 1'b0;
    end else begin
      if (wr_tsave)   tsave_q   <= wdata;
      if (wr_enable)  enable_q  <= wdata[NIRQ-1:0];
      if (wr_haltctl) haltctl_q <= wdata[0];
      pend_q <= (pend_q & ~pend_clr) | irq_rise;
    end
  end

  // Trap sequencing: state, registered trap, cause captured on entry to REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      trap_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == REQ);
      if (state_q == IDLE && state_d == REQ) cause_q <= lowest;
    end
  end

  // Next-state: acknowledge via TSAVE write, completion via EOI, no nesting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pe != '0) state_d = REQ;
      REQ: begin
        if (wr_tsave)        state_d = SERVICE;
        else if (pe == '0)   state_d = IDLE;
      end
      SERVICE: if (wr_eoi)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Zero-wait read mux; narrow registers are zero-extended.
  always_comb begin
    logic [31:0] pend_ext, enable_ext;
    pend_ext   = '0;
    enable_ext = '0;
    pend_ext[NIRQ-1:0]   = pend_q;
    enable_ext[NIRQ-1:0] = enable_q;
    rdata = '0;
    if (strobe && !rw && sel) begin
      if (off[5] == 1'b0) begin
        rdata = vec_q[off[4:0]];
      end else begin
        case (off)
          6'h20:   rdata = tsave_q;
          6'h21:   rdata = pend_ext;
          6'h22:   rdata = enable_ext;
          6'h23:   rdata = {31'd0, haltctl_q};
          6'h24:   rdata = {27'd0, cause_q};
          default: rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eib.sv
// tb/tb_eib.sv - directed self-checking bench for eib
module tb_eib;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          NIRQ = 8;

  localparam logic [31:0] A_TSAVE   = BASE + 32'h20;
  localparam logic [31:0] A_PEND    = BASE + 32'h21;
  localparam logic [31:0] A_ENABLE  = BASE + 32'h22;
  localparam logic [31:0] A_HALTCTL = BASE + 32'h23;
  localparam logic [31:0] A_CAUSE   = BASE + 32'h24;
  localparam logic [31:0] A_EOI     = BASE + 32'h25;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            strobe;
  logic            rw;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [NIRQ-1:0] irq;
  logic            trap;
  logic            halt;

  int n_tests = 0;
  int n_fail  = 0;

  eib #(.BASE(BASE), .NIRQ(NIRQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (strobe),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .trap    (trap),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    strobe = 1'b1; rw = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    strobe = 1'b1; rw = 1'b0; addr = a;
    #1;
    d = rdata;
    strobe = 1'b0; addr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0; strobe = 1'b0; rw = 1'b0; addr = '0; wdata = '0; irq = '0;
    tick(3);
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b want 0", trap); end
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", halt); end
    bus_read(A_PEND, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", rd); end
    bus_read(BASE, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_vec0: got %h want 0", rd); end
    reset_n = 1'b1;
    tick(5);
  endtask

  task automatic test_rw();
    logic [31:0] rd;
    bus_write(BASE + 32'h5, 32'h1234);
    bus_read(BASE + 32'h5, rd);
    n_tests++; if (rd !== 32'h1234) begin n_fail++; $display("FAIL rw_vec5: got %h want 1234", rd); end
    bus_read(BASE + 32'h30, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rw_unmapped30: got %h want 0", rd); end
    strobe = 1'b0; rw = 1'b0; addr = BASE + 32'h5;
    #1;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rw_nostrobe: got %h want 0", rdata); end
    addr = '0;
    bus_write(BASE + 32'h45, 32'hDEAD_BEEF);
    bus_read(BASE + 32'h5, rd);
    n_tests++; if (rd !== 32'h1234) begin n_fail++; $display("FAIL rw_outside_window: got %h want 1234", rd); end
    bus_write(BASE + 32'h26, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h26, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rw_unmapped26: got %h want 0", rd); end
    bus_write(A_ENABLE, 32'hFFFF_FFFF);
    bus_read(A_ENABLE, rd);
    n_tests++; if (rd !== 32'h0000_00FF) begin n_fail++; $display("FAIL rw_enable_width: got %h want ff", rd); end
    bus_write(A_ENABLE, 32'h0);
    bus_write(A_HALTCTL, 32'h6);
    bus_read(A_HALTCTL, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rw_haltctl_bit0: got %h want 0", rd); end
    bus_read(A_EOI, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rw_eoi_read: got %h want 0", rd); end
  endtask

  task automatic test_trap_flow();
    logic [31:0] rd;
    bus_write(A_ENABLE, 32'h0C);
    irq[3] = 1'b1;
    #1 irq[2] = 1'b1;
    @(negedge clk);
    irq = '0;
    tick(3);
    bus_read(A_PEND, rd);
    n_tests++; if (rd !== 32'h0C) begin n_fail++; $display("FAIL flow_pend: got %h want 0c", rd); end
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL flow_trap_set: got %b want 1", trap); end
    bus_read(A_CAUSE, rd);
    n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL flow_cause2: got %h want 2", rd); end
    bus_write(A_TSAVE, 32'h40);
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL flow_ack_trap: got %b want 0", trap); end
    tick(2);
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL flow_service_nonest: got %b want 0", trap); end
    bus_read(A_TSAVE, rd);
    n_tests++; if (rd !== 32'h40) begin n_fail++; $display("FAIL flow_tsave: got %h want 40", rd); end
    bus_write(A_PEND, 32'h04);
    bus_read(A_PEND, rd);
    n_tests++; if (rd !== 32'h08) begin n_fail++; $display("FAIL flow_w1c_bit2: got %h want 08", rd); end
    bus_write(A_EOI, 32'h0);
    tick(1);
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL flow_retrap: got %b want 1", trap); end
    bus_read(A_CAUSE, rd);
    n_tests++; if (rd !== 32'h3) begin n_fail++; $display("FAIL flow_cause3: got %h want 3", rd); end
    bus_write(A_EOI, 32'h0);
    tick(1);
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL flow_eoi_in_req: got %b want 1", trap); end
    bus_write(A_TSAVE, 32'h80);
    bus_write(A_PEND, 32'h08);
    bus_write(A_EOI, 32'h0);
    tick(2);
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL flow_idle: got %b want 0", trap); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    bus_write(A_ENABLE, 32'h0);
    irq[1] = 1'b1;
    @(negedge clk);
    irq = '0;
    @(negedge clk);
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, rd);
    n_tests++; if (rd !== 32'h02) begin n_fail++; $display("FAIL race_set_wins: got %h want 02", rd); end
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL race_plain_clear: got %h want 0", rd); end
  endtask

  task automatic test_abandon();
    logic [31:0] rd;
    bus_write(A_ENABLE, 32'h01);
    irq[0] = 1'b1;
    @(negedge clk);
    irq = '0;
    tick(3);
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL abandon_trap_set: got %b want 1", trap); end
    bus_write(A_PEND, 32'h01);
    tick(1);
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL abandon_trap_drop: got %b want 0", trap); end
    bus_read(A_CAUSE, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abandon_cause: got %h want 0", rd); end
    bus_write(A_TSAVE, 32'h55);
    tick(1);
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL abandon_tsave_idle: got %b want 0", trap); end
    bus_read(A_TSAVE, rd);
    n_tests++; if (rd !== 32'h55) begin n_fail++; $display("FAIL abandon_tsave_val: got %h want 55", rd); end
  endtask

  task automatic test_halt_reset();
    logic [31:0] rd;
    bus_write(A_HALTCTL, 32'h1);
    n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", halt); end
    bus_write(A_ENABLE, 32'h10);
    irq[4] = 1'b1;
    tick(4);
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL hr_trap_set: got %b want 1", trap); end
    bus_read(A_CAUSE, rd);
    n_tests++; if (rd !== 32'h4) begin n_fail++; $display("FAIL hr_cause4: got %h want 4", rd); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL hr_async_trap: got %b want 0", trap); end
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL hr_async_halt: got %b want 0", halt); end
    tick(2);
    reset_n = 1'b1;
    tick(6);
    bus_read(BASE + 32'h5, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hr_vec5: got %h want 0", rd); end
    bus_read(A_TSAVE, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hr_tsave: got %h want 0", rd); end
    bus_read(A_PEND, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hr_pend_no_edge: got %h want 0", rd); end
    bus_read(A_ENABLE, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hr_enable: got %h want 0", rd); end
    bus_read(A_HALTCTL, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hr_haltctl: got %h want 0", rd); end
    bus_read(A_CAUSE, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hr_cause: got %h want 0", rd); end
    n_tests++; if (trap !== 1'b0 || halt !== 1'b0) begin n_fail++; $display("FAIL hr_outputs: got trap=%b halt=%b want 0 0", trap, halt); end
    irq = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rw();
    test_trap_flow();
    test_w1c_race();
    test_abandon();
    test_halt_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eib.md
EIB -- requirements
Module: eib

Interface
REQ-001 Parameter BASE, default 32'h00000100: word address of the 64-word register window; BASE[5:0] SHALL be zero.
REQ-002 Parameter NIRQ, default 8: number of interrupt sources, range 1..32.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 strobe  input  1  bus request from core, valid for one cycle.
REQ-006 rw  input  1  1 = write, 0 = read; qualified by strobe.
REQ-007 addr  input  32  word address from core.
REQ-008 wdata  input  32  write data from core.
REQ-009 rdata  output  32  read data to core.
REQ-010 irq  input  NIRQ  asynchronous level interrupt sources.
REQ-011 trap  output  1  trap request to core.
REQ-012 halt  output  1  halt pull onto the core's wired-or halt bus.

Function
REQ-013 The window SHALL be selected when addr[31:6] == BASE[31:6]; offset = addr[5:0].
REQ-014 Register map: 0x00-0x1F VEC[0..31] (R/W); 0x20 TSAVE (R/W); 0x21 PEND (R, W1C); 0x22 ENABLE (R/W); 0x23 HALTCTL (R/W, bit0 only); 0x24 CAUSE (R, index in [4:0], zero-extended); 0x25 EOI (W, data ignored, reads 0).
REQ-015 The VECTOR_ADDR macro SHALL equal BASE+0x00 and the TRAP_ADDR macro SHALL equal BASE+0x20, so core vector fetches hit VEC and trap return-address saves hit TSAVE.
REQ-016 Reads SHALL be zero-wait: rdata is combinational from addr while strobe=1, rw=0 and window selected; otherwise rdata = 0.
REQ-017 Unmapped offsets (0x26-0x3F) SHALL read 0 and ignore writes; accesses outside the window SHALL have no effect.
REQ-018 Writes SHALL commit on the posedge where strobe=1, rw=1, window selected.
REQ-019 Each irq bit SHALL pass a 2-flop synchronizer; a synchronized 0->1 edge sets the PEND bit the next cycle.
REQ-020 PEND W1C: a written 1 clears that bit; if set and clear coincide, set SHALL win.
REQ-021 Bits of PEND, ENABLE, CAUSE at and above NIRQ SHALL read 0 and ignore writes.
REQ-022 State machine IDLE, REQ, SERVICE; trap = (state == REQ), registered.
REQ-023 IDLE->REQ when (PEND & ENABLE) != 0; on that edge CAUSE latches the lowest set index of PEND & ENABLE.
REQ-024 REQ->SERVICE on a write to TSAVE (the core's trap acknowledge); REQ->IDLE if PEND & ENABLE becomes 0 before acknowledge (CAUSE retained).
REQ-025 SERVICE->IDLE on a write to EOI; EOI in IDLE or REQ SHALL be ignored.
REQ-026 In SERVICE, trap SHALL stay 0 regardless of new pending bits (no nesting); new edges still set PEND.
REQ-027 A write to TSAVE in IDLE or SERVICE SHALL update TSAVE without a state change.
REQ-028 halt = HALTCTL[0], registered; takes effect the cycle after the write.

Reset
REQ-029 reset_n low SHALL immediately force state IDLE, trap 0, halt 0, VEC[*] 0, TSAVE 0, PEND 0, ENABLE 0, HALTCTL 0, CAUSE 0, synchronizers 0; rdata follows REQ-016.
REQ-030 Reset asserted while in REQ or SERVICE SHALL drop trap in the same cycle without waiting for clk; edges present during reset SHALL NOT set PEND after release.

Verification
REQ-031 Write VEC[5]=32'h1234, then read BASE+5 with strobe -> rdata 32'h1234 same cycle; read BASE+0x30 -> 0; read with strobe=0 -> 0.
REQ-032 ENABLE=0x0C, pulse irq[3] then irq[2] -> PEND=0x0C, trap 1, CAUSE=2; write TSAVE=0x40 -> trap 0 next cycle, SERVICE; EOI -> IDLE, trap reasserts with CAUSE=3 after W1C of bit 2 only.
REQ-033 irq[1] edge on same cycle as W1C of PEND bit 1 -> PEND[1] stays 1.
REQ-034 ENABLE=0x01, irq[0] edge -> trap 1; W1C PEND=0x01 before TSAVE write -> trap 0, state IDLE, CAUSE=0.
REQ-035 Write HALTCTL=1 -> halt 1 next cycle; assert reset_n low mid-cycle while trap=1 -> trap and halt 0 immediately, all registers read 0 after release.
